ilm_dot_accum: RTL and testbench
================================

Name: ilm_dot_accum

Overview:
- Streaming dot-product accumulator directly downstream of the 8x8 approximate log multiplier (ILM).
- Consumes one 16-bit unsigned product per accepted beat and sums a group of products terminated by a last flag.
- Presents the group sum, term count and overflow flag on a valid/ready output port.
- Gives the ILM datapath its first sequential stage: handshaking, buffering and group framing.

Parameters:
- PROD_W, 16, product width; matches the multiplier output.
- ACC_W, 24, accumulator and result width; must be at least PROD_W.
- CNT_W, 8, term-counter width.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  reset, synchronous and active-high.
- p_valid_i  input  1  product beat valid.
- p_ready_o  output  1  block can accept a product this cycle.
- p_data_i  input  PROD_W  unsigned product from the multiplier.
- p_last_i  input  1  beat is the final term of the group; sampled only on accept.
- sum_valid_o  output  1  group result held and valid.
- sum_ready_i  input  1  consumer takes the result this cycle.
- sum_data_o  output  ACC_W  group sum.
- sum_count_o  output  CNT_W  number of accepted terms in the group.
- sum_ovf_o  output  1  overflow occurred during the group.

Behaviour:
- Decided: one clock, clk_i; reset rst_i is synchronous and active-high.
- Reset:
  - State goes to IDLE.
  - Accumulator, counter, overflow flag, sum_valid_o, sum_data_o, sum_count_o and sum_ovf_o all go to 0.
  - p_ready_o is 0 while rst_i is high.
  - Reset mid-group discards the partial sum; reset while in HOLD drops the pending result.
- Accept rule: a beat is accepted when p_valid_i & p_ready_o; a result is consumed when sum_valid_o & sum_ready_i.
- States:
  - IDLE: accumulator empty.
    - Accept without last -> ACCUM: acc=p, cnt=1.
    - Accept with last -> HOLD: result = p, count 1.
  - ACCUM: accept without last -> acc+=p, cnt+=1.
    - Accept with last -> HOLD: result = acc+p, count = cnt+1.
    - No accept -> state holds.
  - HOLD: sum_valid_o=1 and result registers stable until consumed.
    - Consume without accept -> IDLE, acc/cnt/ovf cleared.
    - Consume with simultaneous accept -> new group starts from zero with that beat, following the IDLE rules above.
- p_ready_o = ~rst_i & ((state != HOLD) | sum_ready_i). This is a combinational path from sum_ready_i, so full throughput is kept across group boundaries.
- Latency: sum_valid_o rises on the cycle after the last beat is accepted. Sustained rate is one product per cycle, including back-to-back groups.
- Arithmetic:
  - Products are zero-extended to ACC_W.
  - Without the feature, the sum wraps modulo 2^ACC_W.
  - The overflow flag is sticky within a group: set by any carry out of ACC_W, cleared on group start.
- Counter:
  - Saturates at 2^CNT_W-1 and never wraps.
  - Counter saturation also sets the overflow flag.
- Boundary cases:
  - p_last_i with p_valid_i low is ignored.
  - Single-term groups are legal.
  - p_data_i = 0 counts as a term.
  - Consumer stall in HOLD back-pressures the product stream with p_ready_o=0.

Optional Feature:
- Macro: ILM_ACC_SAT_EN.
- Defined:
  - The accumulator clamps to 2^ACC_W-1 on carry out and stays clamped for the rest of the group.
  - The overflow flag is set as usual.
- Undefined: the sum wraps modulo 2^ACC_W, with the overflow flag as described in Behaviour.
- Handshake and latency are identical in both builds.

Decomposition:
- Shared package ilm_pkg holds:
  - PROD_W, ACC_W and CNT_W defaults.
  - State enum {IDLE, ACCUM, HOLD}.
- One sub-module, ilm_acc_adder: combinational ACC_W adder producing a wrapped or clamped sum (per ILM_ACC_SAT_EN) plus a carry-out flag.

Test Plan:
- Reset in HOLD:
  - Assert rst_i while a result is held -> next cycle sum_valid_o=0, p_ready_o=0 during reset.
  - After release, group {1, last} -> sum_data_o=1, count=1.
- Basic group: beats 100, 200, 300 (last on 300), sum_ready_i=1 -> one cycle after last: sum_data_o=600, sum_count_o=3, sum_ovf_o=0, sum_valid_o high one cycle.
- Back-to-back groups: group {5,7 last} then immediately {9 last}, sum_ready_i=1 -> p_ready_o never drops; results 12 (count 2) then 9 (count 1) on consecutive valid cycles.
- Back-pressure: hold sum_ready_i=0 for 4 cycles after group {65025 last} -> p_ready_o=0, sum_data_o stable at 65025; release -> product accepted in the same cycle and starts a fresh group.
- Overflow, ACC_W=16: products 0xFFFF then 0x0002 last ->
  - Without ILM_ACC_SAT_EN: sum 0x0001, ovf=1.
  - With ILM_ACC_SAT_EN: sum 0xFFFF, ovf=1.
- Counter saturation, CNT_W=2: 5 beats of 1 -> sum_count_o=3, sum_ovf_o=1, sum_data_o=5.

Source files
------------

// File: rtl/ilm_pkg.sv
// Shared widths and FSM encoding for the ILM dot-product accumulator.
package ilm_pkg;
    localparam int ILM_PROD_W = 16;
    localparam int ILM_ACC_W  = 24;
    localparam int ILM_CNT_W  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;
endpackage

// File: rtl/ilm_acc_adder.sv
// Accumulator adder: ACC_W-bit sum plus carry-out; clamps to all-ones on carry when ILM_ACC_SAT_EN is defined.
// Latency: combinational, zero cycles.
// Backpressure: none, pure datapath.
module ilm_acc_adder #(
    parameter int ACC_W = 24
) (
    input  logic [ACC_W-1:0] a,
    input  logic [ACC_W-1:0] b,
    output logic [ACC_W-1:0] sum,
    output logic             carry
);
    logic [ACC_W:0] full;

    assign full  = {1'b0, a} + {1'b0, b};
    assign carry = full[ACC_W];

`ifdef ILM_ACC_SAT_EN
    // Once clamped, any further non-zero term carries again, so the group stays pinned at max.
    assign sum = carry ? {ACC_W{1'b1}} : full[ACC_W-1:0];
`else
    assign sum = full[ACC_W-1:0];
`endif
endmodule

// File: rtl/ilm_dot_accum.sv
// Streaming dot-product accumulator behind the ILM; group sum/count/ovf out on valid/ready (ILM_ACC_SAT_EN clamps the sum).
// Latency: sum_valid_o rises one cycle after the last beat is accepted; one product per cycle sustained.
// Backpressure: p_ready_o drops only while a result is held and sum_ready_i is low (combinational from sum_ready_i).
module ilm_dot_accum
    import ilm_pkg::*;
#(
    parameter int PROD_W = ILM_PROD_W,
    parameter int ACC_W  = ILM_ACC_W,
    parameter int CNT_W  = ILM_CNT_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              p_valid_i,
    output logic              p_ready_o,
    input  logic [PROD_W-1:0] p_data_i,
    input  logic              p_last_i,
    output logic              sum_valid_o,
    input  logic              sum_ready_i,
    output logic [ACC_W-1:0]  sum_data_o,
    output logic [CNT_W-1:0]  sum_count_o,
    output logic              sum_ovf_o
);
    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             ovf;

    logic             accept;
    logic             consume;
    logic [ACC_W-1:0] base_acc;
    logic [CNT_W-1:0] base_cnt;
    logic             base_ovf;
    logic [ACC_W-1:0] nxt_acc;
    logic             carry;
    logic             cnt_full;
    logic [CNT_W-1:0] nxt_cnt;
    logic             nxt_ovf;

    assign p_ready_o = ~rst_i & ((state != HOLD) | sum_ready_i);
    assign accept    = p_valid_i & p_ready_o;
    assign consume   = sum_valid_o & sum_ready_i;

    // Only ACCUM carries a partial group; IDLE and a consumed HOLD both start from zero.
    always_comb begin
        base_acc = '0;
        base_cnt = '0;
        base_ovf = 1'b0;
        if (state == ACCUM) begin
            base_acc = acc;
            base_cnt = cnt;
            base_ovf = ovf;
        end
    end

    ilm_acc_adder #(.ACC_W(ACC_W)) u_adder (
        .a     (base_acc),
        .b     (ACC_W'(p_data_i)),
        .sum   (nxt_acc),
        .carry (carry)
    );

    assign cnt_full = &base_cnt;
    assign nxt_cnt  = cnt_full ? base_cnt : base_cnt + CNT_W'(1);
    assign nxt_ovf  = base_ovf | carry | cnt_full;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            acc         <= '0;
            cnt         <= '0;
            ovf         <= 1'b0;
            sum_valid_o <= 1'b0;
            sum_data_o  <= '0;
            sum_count_o <= '0;
            sum_ovf_o   <= 1'b0;
        end else if (accept) begin
            if (p_last_i) begin
                state       <= HOLD;
                sum_valid_o <= 1'b1;
                sum_data_o  <= nxt_acc;
                sum_count_o <= nxt_cnt;
                sum_ovf_o   <= nxt_ovf;
                acc         <= '0;
                cnt         <= '0;
                ovf         <= 1'b0;
            end else begin
                state       <= ACCUM;
                sum_valid_o <= 1'b0;
                acc         <= nxt_acc;
                cnt         <= nxt_cnt;
                ovf         <= nxt_ovf;
            end
        end else if (consume) begin
            state       <= IDLE;
            sum_valid_o <= 1'b0;
            acc         <= '0;
            cnt         <= '0;
            ovf         <= 1'b0;
        end
    end
endmodule

// File: tb/tb_ilm_dot_accum.sv
// Self-checking bench: default-width instance plus an ACC_W=16/CNT_W=2 instance driven in lockstep.
module tb_ilm_dot_accum;
    logic        clk = 1'b0;
    logic        rst;
    logic        p_valid, p_last, sum_ready;
    logic [15:0] p_data;

    logic        p_ready, sum_valid, sum_ovf;
    logic [23:0] sum_data;
    logic [7:0]  sum_count;
    logic        s_p_ready, s_sum_valid, s_sum_ovf;
    logic [15:0] s_sum_data;
    logic [1:0]  s_sum_count;

    logic        o_ready, o_vld, o_ovf, o_sready, o_svld, o_sovf, o_acc, o_cons;
    logic [23:0] o_data;
    logic [7:0]  o_cnt;
    logic [15:0] o_sdata;
    logic [1:0]  o_scnt;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        longint unsigned s;
        int unsigned     c;
        bit              ov;
    } res_t;

    int unsigned grp[$];
    res_t        exp_big[$];
    res_t        exp_small[$];

    always #5 clk = ~clk;

    ilm_dot_accum u_dut (
        .clk_i(clk), .rst_i(rst), .p_valid_i(p_valid), .p_ready_o(p_ready),
        .p_data_i(p_data), .p_last_i(p_last), .sum_valid_o(sum_valid),
        .sum_ready_i(sum_ready), .sum_data_o(sum_data), .sum_count_o(sum_count),
        .sum_ovf_o(sum_ovf)
    );

    ilm_dot_accum #(.PROD_W(16), .ACC_W(16), .CNT_W(2)) u_small (
        .clk_i(clk), .rst_i(rst), .p_valid_i(p_valid), .p_ready_o(s_p_ready),
        .p_data_i(p_data), .p_last_i(p_last), .sum_valid_o(s_sum_valid),
        .sum_ready_i(sum_ready), .sum_data_o(s_sum_data), .sum_count_o(s_sum_count),
        .sum_ovf_o(s_sum_ovf)
    );

    // Reference: plain integer sum of the group's terms with wrap or clamp at 2^accw.
    function automatic res_t model(input int accw, input int cntw);
        res_t            r;
        longint unsigned lim;
        int unsigned     cmax;
        lim  = 64'd1 << accw;
        cmax = (32'd1 << cntw) - 1;
        r.s  = 0;
        r.ov = 1'b0;
        foreach (grp[i]) begin
            r.s += grp[i];
            if (r.s >= lim) begin
                r.ov = 1'b1;
`ifdef ILM_ACC_SAT_EN
                r.s = lim - 1;
`else
                r.s -= lim;
`endif
            end
        end
        if (grp.size() > cmax) begin
            r.c  = cmax;
            r.ov = 1'b1;
        end else begin
            r.c = grp.size();
        end
        return r;
    endfunction

    task automatic cyc(input logic v, input logic [15:0] d, input logic l, input logic r);
        p_valid = v; p_data = d; p_last = l; sum_ready = r;
        @(negedge clk);
        o_ready = p_ready;    o_vld = sum_valid;    o_data = sum_data;    o_cnt = sum_count;    o_ovf = sum_ovf;
        o_sready = s_p_ready; o_svld = s_sum_valid; o_sdata = s_sum_data; o_scnt = s_sum_count; o_sovf = s_sum_ovf;
        o_acc  = v & p_ready;
        o_cons = sum_valid & r;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        cyc(1'b1, 16'd5, 1'b1, 1'b0);
        n_vec++; if (o_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready got=%b want=0", o_ready); end
        cyc(1'b0, 16'd0, 1'b0, 1'b0);
        n_vec++; if (o_vld !== 1'b0 || o_svld !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b/%b want=0/0", o_vld, o_svld); end
        n_vec++; if (o_data !== 24'd0 || o_cnt !== 8'd0 || o_ovf !== 1'b0) begin n_err++; $display("FAIL reset_result got=%0d/%0d/%b want=0/0/0", o_data, o_cnt, o_ovf); end
        rst = 1'b0;
        cyc(1'b0, 16'd0, 1'b0, 1'b0);
        n_vec++; if (o_ready !== 1'b1) begin n_err++; $display("FAIL reset_release_ready got=%b want=1", o_ready); end
    endtask

    task automatic test_reset_hold;
        cyc(1'b1, 16'd7, 1'b1, 1'b0);
        cyc(1'b0, 16'd0, 1'b0, 1'b0);
        n_vec++; if (o_vld !== 1'b1 || o_ready !== 1'b0) begin n_err++; $display("FAIL hold_before_reset got vld=%b rdy=%b want 1/0", o_vld, o_ready); end
        rst = 1'b1;
        cyc(1'b1, 16'd3, 1'b1, 1'b0);
        n_vec++; if (o_ready !== 1'b0) begin n_err++; $display("FAIL hold_reset_ready got=%b want=0", o_ready); end
        rst = 1'b0;
        cyc(1'b0, 16'd0, 1'b0, 1'b0);
        n_vec++; if (o_vld !== 1'b0 || o_ready !== 1'b1) begin n_err++; $display("FAIL hold_reset_drop got vld=%b rdy=%b want 0/1", o_vld, o_ready); end
        cyc(1'b1, 16'd1, 1'b1, 1'b1);
        cyc(1'b0, 16'd0, 1'b0, 1'b1);
        n_vec++; if (o_vld !== 1'b1 || o_data !== 24'd1 || o_cnt !== 8'd1) begin n_err++; $display("FAIL hold_reset_regroup got vld=%b sum=%0d cnt=%0d want 1/1/1", o_vld, o_data, o_cnt); end
        cyc(1'b0, 16'd0, 1'b0, 1'b1);
    endtask

    task automatic test_basic;
        cyc(1'b1, 16'd100, 1'b0, 1'b1);
        cyc(1'b0, 16'd999, 1'b1, 1'b1);
        cyc(1'b1, 16'd200, 1'b0, 1'b1);
        cyc(1'b1, 16'd300, 1'b1, 1'b1);
        n_vec++; if (o_vld !== 1'b0) begin n_err++; $display("FAIL basic_early_valid got=%b want=0", o_vld); end
        cyc(1'b0, 16'd0, 1'b0, 1'b1);
        n_vec++; if (o_vld !== 1'b1 || o_data !== 24'd600 || o_cnt !== 8'd3 || o_ovf !== 1'b0)
            begin n_err++; $display("FAIL basic_sum got vld=%b sum=%0d cnt=%0d ovf=%b want 1/600/3/0", o_vld, o_data, o_cnt, o_ovf); end
        cyc(1'b0, 16'd0, 1'b0, 1'b1);
        n_vec++; if (o_vld !== 1'b0) begin n_err++; $display("FAIL basic_one_cycle got=%b want=0", o_vld); end
    endtask

    task automatic test_back_to_back;
        cyc(1'b1, 16'd5, 1'b0, 1'b1);
        n_vec++; if (o_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready0 got=%b want=1", o_ready); end
        cyc(1'b1, 16'd7, 1'b1, 1'b1);
        n_vec++; if (o_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready1 got=%b want=1", o_ready); end
        cyc(1'b1, 16'd9, 1'b1, 1'b1);
        n_vec++; if (o_ready !== 1'b1 || o_vld !== 1'b1 || o_data !== 24'd12 || o_cnt !== 8'd2)
            begin n_err++; $display("FAIL b2b_first got rdy=%b vld=%b sum=%0d cnt=%0d want 1/1/12/2", o_ready, o_vld, o_data, o_cnt); end
        cyc(1'b0, 16'd0, 1'b0, 1'b1);
        n_vec++; if (o_vld !== 1'b1 || o_data !== 24'd9 || o_cnt !== 8'd1)
            begin n_err++; $display("FAIL b2b_second got vld=%b sum=%0d cnt=%0d want 1/9/1", o_vld, o_data, o_cnt); end
        cyc(1'b0, 16'd0, 1'b0, 1'b1);
    endtask

    task automatic test_backpressure;
        cyc(1'b1, 16'd65025, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 16'd111, 1'b1, 1'b0);
            n_vec++; if (o_ready !== 1'b0 || o_vld !== 1'b1 || o_data !== 24'd65025)
                begin n_err++; $display("FAIL bp_stall%0d got rdy=%b vld=%b sum=%0d want 0/1/65025", i, o_ready, o_vld, o_data); end
        end
        cyc(1'b1, 16'd111, 1'b1, 1'b1);
        n_vec++; if (o_ready !== 1'b1 || o_data !== 24'd65025) begin n_err++; $display("FAIL bp_release got rdy=%b sum=%0d want 1/65025", o_ready, o_data); end
        cyc(1'b0, 16'd0, 1'b0, 1'b1);
        n_vec++; if (o_vld !== 1'b1 || o_data !== 24'd111 || o_cnt !== 8'd1)
            begin n_err++; $display("FAIL bp_fresh got vld=%b sum=%0d cnt=%0d want 1/111/1", o_vld, o_data, o_cnt); end
        cyc(1'b0, 16'd0, 1'b0, 1'b1);
        n_vec++; if (o_vld !== 1'b0) begin n_err++; $display("FAIL bp_drain got=%b want=0", o_vld); end
    endtask

    task automatic test_overflow;
        logic [15:0] want;
`ifdef ILM_ACC_SAT_EN
        want = 16'hFFFF;
`else
        want = 16'h0001;
`endif
        cyc(1'b1, 16'hFFFF, 1'b0, 1'b1);
        cyc(1'b1, 16'h0002, 1'b1, 1'b1);
        cyc(1'b0, 16'd0, 1'b0, 1'b1);
        n_vec++; if (o_svld !== 1'b1 || o_sdata !== want || o_sovf !== 1'b1 || o_scnt !== 2'd2)
            begin n_err++; $display("FAIL ovf_small got vld=%b sum=%h ovf=%b cnt=%0d want 1/%h/1/2", o_svld, o_sdata, o_sovf, o_scnt, want); end
        n_vec++; if (o_data !== 24'h010001 || o_ovf !== 1'b0) begin n_err++; $display("FAIL ovf_wide got sum=%h ovf=%b want 010001/0", o_data, o_ovf); end
        cyc(1'b0, 16'd0, 1'b0, 1'b1);
    endtask

    task automatic test_cnt_sat;
        for (int i = 0; i < 5; i++) cyc(1'b1, 16'd1, (i == 4), 1'b1);
        cyc(1'b0, 16'd0, 1'b0, 1'b1);
        n_vec++; if (o_scnt !== 2'd3 || o_sovf !== 1'b1 || o_sdata !== 16'd5)
            begin n_err++; $display("FAIL cnt_sat got cnt=%0d ovf=%b sum=%0d want 3/1/5", o_scnt, o_sovf, o_sdata); end
        n_vec++; if (o_cnt !== 8'd5 || o_ovf !== 1'b0) begin n_err++; $display("FAIL cnt_wide got cnt=%0d ovf=%b want 5/0", o_cnt, o_ovf); end
        cyc(1'b1, 16'd0, 1'b0, 1'b1);
        cyc(1'b1, 16'd0, 1'b1, 1'b1);
        cyc(1'b0, 16'd0, 1'b0, 1'b1);
        n_vec++; if (o_vld !== 1'b1 || o_data !== 24'd0 || o_cnt !== 8'd2) begin n_err++; $display("FAIL zero_terms got vld=%b sum=%0d cnt=%0d want 1/0/2", o_vld, o_data, o_cnt); end
        cyc(1'b0, 16'd0, 1'b0, 1'b1);
    endtask

    task automatic test_random;
        logic        v, l, r, want_rdy;
        logic [15:0] d;
        res_t        eb, es;
        grp.delete();
        for (int n = 0; n < 600; n++) begin
            v = ($urandom_range(0, 3) != 0);
            l = ($urandom_range(0, 3) == 0);
            r = ($urandom_range(0, 2) != 0);
            case ($urandom_range(0, 5))
                0:       d = 16'h0000;
                1:       d = 16'hFFFF;
                default: d = 16'($urandom);
            endcase
            want_rdy = (exp_big.size() == 0) | r;
            cyc(v, d, l, r);
            n_vec++; if (o_ready !== want_rdy || o_sready !== want_rdy)
                begin n_err++; $display("FAIL rnd_ready cyc=%0d got=%b/%b want=%b", n, o_ready, o_sready, want_rdy); end
            n_vec++; if (o_vld !== (exp_big.size() != 0) || o_svld !== o_vld)
                begin n_err++; $display("FAIL rnd_valid cyc=%0d got=%b/%b want=%b", n, o_vld, o_svld, exp_big.size() != 0); end
            if (o_cons) begin
                if (exp_big.size() == 0) begin
                    n_vec++; n_err++; $display("FAIL rnd_spurious cyc=%0d got result with none pending", n);
                end else begin
                    eb = exp_big.pop_front();
                    es = exp_small.pop_front();
                    n_vec++; if (o_data !== 24'(eb.s) || o_cnt !== 8'(eb.c) || o_ovf !== eb.ov)
                        begin n_err++; $display("FAIL rnd_wide cyc=%0d got %0d/%0d/%b want %0d/%0d/%b", n, o_data, o_cnt, o_ovf, eb.s, eb.c, eb.ov); end
                    n_vec++; if (o_sdata !== 16'(es.s) || o_scnt !== 2'(es.c) || o_sovf !== es.ov)
                        begin n_err++; $display("FAIL rnd_small cyc=%0d got %0d/%0d/%b want %0d/%0d/%b", n, o_sdata, o_scnt, o_sovf, es.s, es.c, es.ov); end
                end
            end
            if (o_acc) begin
                grp.push_back(32'(d));
                if (l) begin
                    exp_big.push_back(model(24, 8));
                    exp_small.push_back(model(16, 2));
                    grp.delete();
                end
            end
        end
    endtask

    initial begin
        rst = 1'b0; p_valid = 1'b0; p_data = '0; p_last = 1'b0; sum_ready = 1'b0;
        test_reset;
        test_basic;
        test_back_to_back;
        test_backpressure;
        test_overflow;
        test_cnt_sat;
        test_reset_hold;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
